otg_hpi_sequencer: RTL
======================

// Module: otg_hpi_sequencer
// PURPOSE
//  Hardware master for the CY7C67200 HPI port (otg_hpi_* pins of final_soc): turns single
//  request/response transactions into correctly timed cs/r/w/address/data pin sequences.
//  Replaces software bit-banging of the HPI PIOs by the NIOS; also issues the chip reset pulse.
// PARAMETERS
//  SETUP_CYC   2      cycles address/cs/data valid before r/w strobe asserts (>=1)
//  STROBE_CYC  6      cycles r or w held low (>=1)
//  HOLD_CYC    2      cycles address/cs/data held after strobe release (>=1)
//  RST_CYC     1000   cycles otg_hpi_reset held low per chip-reset request
// PORTS
//  clk              in   1   system clock
//  reset            in   1   async, active-high
//  req_valid        in   1   transaction request
//  req_ready        out  1   sequencer can accept a request this cycle
//  req_write        in   1   1=write, 0=read
//  req_addr         in   2   HPI register: 0 DATA, 1 MAILBOX, 2 ADDRESS, 3 STATUS
//  req_wdata        in   16  write data
//  req_mem          in   1   memory op (only with OTG_HPI_MEMOP_EN; else ignored)
//  req_memaddr      in   16  chip memory address for memory op
//  rst_req          in   1   request chip reset pulse
//  rsp_valid        out  1   one-cycle pulse: transaction finished
//  rsp_rdata        out  16  read data, valid with rsp_valid (0 after writes)
//  otg_hpi_address  out  2   HPI address pins
//  otg_hpi_cs       out  1   chip select, active-low
//  otg_hpi_r        out  1   read strobe, active-low
//  otg_hpi_w        out  1   write strobe, active-low
//  otg_hpi_reset    out  1   chip reset, active-low
//  otg_hpi_data_out out  16  data driven to pins
//  otg_hpi_data_oe  out  1   tristate enable for data_out
//  otg_hpi_data_in  in   16  data from pins
// BEHAVIOUR
//  Reset: cs/r/w/reset pins=1, address=0, data_out=0, oe=0, rsp_valid=0, rsp_rdata=0,
//   req_ready=0, state=IDLE; ready rises the first cycle after reset deasserts.
//  All pin outputs registered. FSM: IDLE, SETUP, STROBE, HOLD, CHIPRST.
//  IDLE: req_ready=1. Accept on req_valid&&req_ready: latch write/addr/wdata; ->SETUP.
//   rst_req has priority over req_valid in the same cycle (request not accepted).
//  SETUP (SETUP_CYC): cs=0, address driven; oe=1 and data_out=wdata for writes.
//  STROBE (STROBE_CYC): r=0 (read) or w=0 (write). Read: data_in captured on last STROBE cycle.
//  HOLD (HOLD_CYC): r/w=1, cs=0, address/data held; last cycle ->IDLE, rsp_valid=1 next cycle.
//  Latency: accept to rsp_valid = SETUP_CYC+STROBE_CYC+HOLD_CYC+1 cycles (default 11).
//  CHIPRST: otg_hpi_reset=0 for RST_CYC cycles, cs/r/w=1, oe=0, req_ready=0; then IDLE;
//   no rsp_valid. rst_req while busy is ignored (caller re-asserts); level-held rst_req
//   re-enters CHIPRST after each pulse.
//  Back-to-back: next request accepted in IDLE cycle that issues rsp_valid; cs deasserts >=1 cycle.
//  Counter: single down-counter, width $clog2(max param)+1, reloaded per state; no wrap.
//  Async reset mid-transaction: pins return to idle levels immediately; transaction lost.
// CONFIGURATION
//  OTG_HPI_MEMOP_EN defined: req_mem=1 runs write of req_memaddr to ADDRESS (reg 2), then,
//   with >=1 cycle cs high between, access to DATA (reg 0) using req_write/req_wdata; single
//   rsp_valid at end; latency = 2*(SETUP+STROBE+HOLD)+2. req_addr ignored when req_mem=1.
//  Undefined: req_mem/req_memaddr unused; every request is one register access.
// STRUCTURE
//  Package otg_hpi_pkg: hpi_reg_e (DATA=0,MAILBOX=1,ADDRESS=2,STATUS=3), hpi_state_e.
//  No sub-module; single FSM + counter. Top-level ties data_oe to the pin tristate.
// TESTING
//  Write reg1 0xBEEF -> cs low 10 cycles, w low cycles 3-8, data_out=0xBEEF oe=1, rsp at 11.
//  Read reg3, data_in=0x1234 at last strobe -> rsp_rdata=0x1234, r low 6 cycles, oe=0.
//  Two back-to-back reads -> cs high >=1 cycle between, both rsp_valid, correct data.
//  rst_req and req_valid same cycle -> reset pin low exactly 1000 cycles, request not acked.
//  Async reset during STROBE -> pins cs/r/w=1 same cycle, req_ready=1 after release.
//  MEMOP_EN: mem write addr 0x1000 data 0x00AA -> ADDRESS wr 0x1000, DATA wr 0x00AA, one rsp.

Source files
------------

// File: rtl/otg_hpi_pkg.sv
// Shared types for the CY7C67200 HPI master: register map, sequencer states
// and a small helper for sizing the shared cycle counter.
package otg_hpi_pkg;

  typedef enum logic [1:0] {
    DATA    = 2'd0,
    MAILBOX = 2'd1,
    ADDRESS = 2'd2,
    STATUS  = 2'd3
  } hpi_reg_e;

  // GAP is only reachable in the memory-op build: it guarantees cs goes high
  // for one cycle between the ADDRESS write and the DATA access.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    STROBE  = 3'd2,
    HOLD    = 3'd3,
    CHIPRST = 3'd4,
    GAP     = 3'd5
  } hpi_state_e;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/otg_hpi_sequencer.sv
// HPI pin sequencer: one request -> cs/address/strobe/data timing on the otg_hpi_* pins,
// plus the chip reset pulse. Define OTG_HPI_MEMOP_EN for the two-access memory op.
import otg_hpi_pkg::*;

module otg_hpi_sequencer #(
  parameter int SETUP_CYC  = 2,
  parameter int STROBE_CYC = 6,
  parameter int HOLD_CYC   = 2,
  parameter int RST_CYC    = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_addr,
  input  logic [15:0] req_wdata,
  input  logic        req_mem,
  input  logic [15:0] req_memaddr,
  input  logic        rst_req,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic [1:0]  otg_hpi_address,
  output logic        otg_hpi_cs,
  output logic        otg_hpi_r,
  output logic        otg_hpi_w,
  output logic        otg_hpi_reset,
  output logic [15:0] otg_hpi_data_out,
  output logic        otg_hpi_data_oe,
  input  logic [15:0] otg_hpi_data_in
);

  localparam int MAX_CYC = max4(SETUP_CYC, STROBE_CYC, HOLD_CYC, RST_CYC);
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  localparam logic [CNT_W-1:0] LD_SETUP  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] LD_STROBE = CNT_W'(STROBE_CYC - 1);
  localparam logic [CNT_W-1:0] LD_HOLD   = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] LD_RST    = CNT_W'(RST_CYC - 1);

  hpi_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             acc_write_q, acc_write_d;
  hpi_reg_e         acc_addr_q, acc_addr_d;
  logic [15:0]      acc_wdata_q, acc_wdata_d;
  logic [15:0]      rdata_q, rdata_d;
  logic             rsp_valid_d;
  logic [15:0]      rsp_rdata_d;
  logic             busy_d;
  logic             last_cnt;

`ifdef OTG_HPI_MEMOP_EN
  logic        mem_pend_q, mem_pend_d;
  logic        pend_write_q, pend_write_d;
  logic [15:0] pend_wdata_q, pend_wdata_d;
`else
  logic unused_memop;
  assign unused_memop = ^{req_mem, req_memaddr};
`endif

  assign last_cnt = (cnt_q == '0);

  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    state_d     = state_q;
    cnt_d       = last_cnt ? cnt_q : cnt_q - CNT_W'(1);
    acc_write_d = acc_write_q;
    acc_addr_d  = acc_addr_q;
    acc_wdata_d = acc_wdata_q;
    rdata_d     = rdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata;
`ifdef OTG_HPI_MEMOP_EN
    mem_pend_d   = mem_pend_q;
    pend_write_d = pend_write_q;
    pend_wdata_d = pend_wdata_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (rst_req) begin
          state_d = CHIPRST;
          cnt_d   = LD_RST;
        end else if (req_valid && req_ready) begin
          state_d     = SETUP;
          cnt_d       = LD_SETUP;
          acc_write_d = req_write;
          acc_addr_d  = hpi_reg_e'(req_addr);
          acc_wdata_d = req_wdata;
`ifdef OTG_HPI_MEMOP_EN
          mem_pend_d = 1'b0;
          if (req_mem) begin
            // First leg loads the chip address pointer; the real access follows.
            acc_write_d  = 1'b1;
            acc_addr_d   = ADDRESS;
            acc_wdata_d  = req_memaddr;
            mem_pend_d   = 1'b1;
            pend_write_d = req_write;
            pend_wdata_d = req_wdata;
          end
`endif
        end
      end
      SETUP: begin
        if (last_cnt) begin
          state_d = STROBE;
          cnt_d   = LD_STROBE;
        end
      end
      STROBE: begin
        if (last_cnt) begin
          if (!acc_write_q) rdata_d = otg_hpi_data_in;
          state_d = HOLD;
          cnt_d   = LD_HOLD;
        end
      end
      HOLD: begin
        if (last_cnt) begin
`ifdef OTG_HPI_MEMOP_EN
          if (mem_pend_q) begin
            state_d = GAP;
          end else begin
            state_d     = IDLE;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = acc_write_q ? 16'h0000 : rdata_q;
          end
`else
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = acc_write_q ? 16'h0000 : rdata_q;
`endif
        end
      end
      GAP: begin
`ifdef OTG_HPI_MEMOP_EN
        state_d     = SETUP;
        cnt_d       = LD_SETUP;
        acc_write_d = pend_write_q;
        acc_addr_d  = DATA;
        acc_wdata_d = pend_wdata_q;
        mem_pend_d  = 1'b0;
`else
        state_d = IDLE;
`endif
      end
      CHIPRST: begin
        if (last_cnt) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Pins are decoded from the next state so they change on the same edge as the FSM.
  assign busy_d = (state_d == SETUP) || (state_d == STROBE) || (state_d == HOLD);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= IDLE;
      cnt_q            <= '0;
      acc_write_q      <= 1'b0;
      acc_addr_q       <= DATA;
      acc_wdata_q      <= 16'h0000;
      rdata_q          <= 16'h0000;
      rsp_valid        <= 1'b0;
      rsp_rdata        <= 16'h0000;
      req_ready        <= 1'b0;
      otg_hpi_cs       <= 1'b1;
      otg_hpi_r        <= 1'b1;
      otg_hpi_w        <= 1'b1;
      otg_hpi_reset    <= 1'b1;
      otg_hpi_address  <= 2'd0;
      otg_hpi_data_out <= 16'h0000;
      otg_hpi_data_oe  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      acc_write_q      <= acc_write_d;
      acc_addr_q       <= acc_addr_d;
      acc_wdata_q      <= acc_wdata_d;
      rdata_q          <= rdata_d;
      rsp_valid        <= rsp_valid_d;
      rsp_rdata        <= rsp_rdata_d;
      req_ready        <= (state_d == IDLE);
      otg_hpi_cs       <= !busy_d;
      otg_hpi_r        <= !((state_d == STROBE) && !acc_write_d);
      otg_hpi_w        <= !((state_d == STROBE) && acc_write_d);
      otg_hpi_reset    <= (state_d != CHIPRST);
      otg_hpi_address  <= busy_d ? acc_addr_d : 2'd0;
      otg_hpi_data_out <= (busy_d && acc_write_d) ? acc_wdata_d : 16'h0000;
      otg_hpi_data_oe  <= busy_d && acc_write_d;
    end
  end

`ifdef OTG_HPI_MEMOP_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_pend_q   <= 1'b0;
      pend_write_q <= 1'b0;
      pend_wdata_q <= 16'h0000;
    end else begin
      mem_pend_q   <= mem_pend_d;
      pend_write_q <= pend_write_d;
      pend_wdata_q <= pend_wdata_d;
    end
  end
`endif

endmodule
